// File: rtl/scan_test_seq_if.sv
// Signal bundle between board test control / scan-chained counter and the
// scan-test sequencer. Clock and reset stay as plain ports on the sequencer.
interface scan_test_seq_if #(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned CAP_W     = 4
);
  logic                 aStart;
  logic                 aAbort;
  logic [CHAIN_LEN-1:0] aPattern;
  logic [CAP_W-1:0]     aCapCycles;
  logic                 aIncrement;
  logic                 bScanOut;
  logic                 bScanEn;
  logic                 bScanIn;
  logic                 bIncrement;
  logic                 bBusy;
  logic                 bDone;
  logic                 bPass;
  logic [CHAIN_LEN-1:0] bCaptured;

  modport master (
    output aStart, aAbort, aPattern, aCapCycles, aIncrement, bScanOut,
    input  bScanEn, bScanIn, bIncrement, bBusy, bDone, bPass, bCaptured
  );

  modport slave (
    input  aStart, aAbort, aPattern, aCapCycles, aIncrement, bScanOut,
    output bScanEn, bScanIn, bIncrement, bBusy, bDone, bPass, bCaptured
  );
endinterface

// File: rtl/scan_test_seq.sv
// Scan-test sequencer: loads a seed into the counter's scan chain, runs C
// functional increments, unloads the chain and checks it against seed + C.
module scan_test_seq #(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned CAP_W     = 4
) (
  input logic            BrdClk,
  input logic            aReset_n,
  scan_test_seq_if.slave bus
);

  localparam int unsigned LEN_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned CNT_W = (LEN_W > CAP_W) ? LEN_W : CAP_W;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
  logic [CHAIN_LEN-1:0] load_sr_q, load_sr_d;
  logic [CAP_W-1:0]     cycles_q, cycles_d;
  logic [CHAIN_LEN-1:0] captured_q, captured_d;
  logic                 pass_q, pass_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_W-1:0]     cycles_ext;
  logic [CHAIN_LEN-1:0] expected;

  assign cycles_ext = CNT_W'(cycles_q);
  // Sum at chain width: carry dropped, C truncated or zero-extended first.
  assign expected   = pattern_q + CHAIN_LEN'(cycles_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    load_sr_d  = load_sr_q;
    cycles_d   = cycles_q;
    captured_d = captured_q;
    pass_d     = pass_q;
    scan_en_d  = 1'b0;
    scan_in_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.aStart) begin
          pattern_d  = bus.aPattern;
          load_sr_d  = {bus.aPattern[CHAIN_LEN-2:0], 1'b0};
          cycles_d   = bus.aCapCycles;
          captured_d = '0;
          pass_d     = 1'b0;
          cnt_d      = '0;
          state_d    = S_LOAD;
          scan_en_d  = 1'b1;
          scan_in_d  = bus.aPattern[CHAIN_LEN-1];
          busy_d     = 1'b1;
        end
      end

      S_LOAD: begin
        if (bus.aAbort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == LAST_SHIFT) begin
          cnt_d  = '0;
          busy_d = 1'b1;
          if (cycles_q == '0) begin
            state_d   = S_UNLOAD;
            scan_en_d = 1'b1;
          end else begin
            state_d = S_CAPTURE;
          end
        end else begin
          // Scan-in for the next load cycle comes off the top of the shifter.
          cnt_d     = cnt_q + CNT_W'(1);
          busy_d    = 1'b1;
          scan_en_d = 1'b1;
          scan_in_d = load_sr_q[CHAIN_LEN-1];
          load_sr_d = {load_sr_q[CHAIN_LEN-2:0], 1'b0};
        end
      end

      S_CAPTURE: begin
        if (bus.aAbort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == cycles_ext - CNT_W'(1)) begin
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_UNLOAD;
          scan_en_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      S_UNLOAD: begin
        if (bus.aAbort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          // First bit sampled ends up in the MSB after CHAIN_LEN shifts.
          captured_d = {captured_q[CHAIN_LEN-2:0], bus.bScanOut};
          if (cnt_q == LAST_SHIFT) begin
            cnt_d   = '0;
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (captured_d == expected);
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            busy_d    = 1'b1;
            scan_en_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pattern_q  <= '0;
      load_sr_q  <= '0;
      cycles_q   <= '0;
      captured_q <= '0;
      pass_q     <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      load_sr_q  <= load_sr_d;
      cycles_q   <= cycles_d;
      captured_q <= captured_d;
      pass_q     <= pass_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  logic increment;

  always_comb begin
    increment = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: increment = bus.aIncrement;
      S_CAPTURE:      increment = 1'b1;
      default:        increment = 1'b0;
    endcase
  end

  assign bus.bScanEn    = scan_en_q;
  assign bus.bScanIn    = scan_in_q;
  assign bus.bIncrement = increment;
  assign bus.bBusy      = busy_q;
  assign bus.bDone      = done_q;
  assign bus.bPass      = pass_q;
  assign bus.bCaptured  = captured_q;

endmodule

// File: tb/tb_scan_test_seq.sv
// Directed bench for scan_test_seq with a behavioural 4-bit scan-chained
// counter (optional bit-2 stuck-at-0 fault) hanging off the sequencer.
module tb_scan_test_seq;

  localparam int unsigned L  = 4;
  localparam int unsigned CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_test_seq_if #(.CHAIN_LEN(L), .CAP_W(CW)) bus();

  scan_test_seq #(.CHAIN_LEN(L), .CAP_W(CW)) dut (
    .BrdClk   (clk),
    .aReset_n (rst_n),
    .bus      (bus)
  );

  // Counter model: scan shifts toward the MSB, scan-out is the MSB register.
  logic [3:0] ctr    = 4'h0;
  logic [3:0] ctr_nx;
  logic       stuck2 = 1'b0;

  always_comb begin
    ctr_nx = ctr;
    if (bus.bScanEn)         ctr_nx = {ctr[2:0], bus.bScanIn};
    else if (bus.bIncrement) ctr_nx = ctr + 4'd1;
    if (stuck2)              ctr_nx[2] = 1'b0;
  end

  always @(posedge clk) ctr <= ctr_nx;

  assign bus.bScanOut = ctr[3];

  int vecs = 0;
  int errs = 0;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input logic [3:0] p, input logic [3:0] c, input logic [3:0] exp_cap,
                         input logic exp_pass, input int exp_lat, input logic with_abort,
                         input string tag);
    int         cyc;
    int         busy_n;
    logic [3:0] sin;
    bus.aPattern   = p;
    bus.aCapCycles = c;
    bus.aStart     = 1'b1;
    bus.aAbort     = with_abort;
    bus.aIncrement = 1'b1;
    tick;
    bus.aStart = 1'b0;
    bus.aAbort = 1'b0;
    cyc    = 1;
    busy_n = 0;
    for (int k = 0; k < 4; k++) begin
      sin[3-k] = bus.bScanIn;
      if (bus.bBusy) busy_n++;
      check_vec({tag, "/load_en"}, 32'(bus.bScanEn), 32'd1);
      if (k < 3) begin
        tick;
        cyc++;
      end
    end
    check_vec({tag, "/load_inc"}, 32'(bus.bIncrement), 32'd0);
    bus.aIncrement = 1'b0;
    check_vec({tag, "/scan_in_seq"}, 32'(sin), 32'(p));
    while (!bus.bDone && cyc < 40) begin
      tick;
      cyc++;
      if (bus.bBusy) busy_n++;
    end
    check_vec({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check_vec({tag, "/captured"}, 32'(bus.bCaptured), 32'(exp_cap));
    check_vec({tag, "/pass"}, 32'(bus.bPass), 32'(exp_pass));
    check_vec({tag, "/busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    tick;
    check_vec({tag, "/done_pulse"}, 32'(bus.bDone), 32'd0);
    check_vec({tag, "/cap_held"}, 32'(bus.bCaptured), 32'(exp_cap));
    check_vec({tag, "/pass_held"}, 32'(bus.bPass), 32'(exp_pass));
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (bus.bDone) dones++;
    end
  endtask

  initial begin
    int cyc;
    int dones;

    bus.aStart     = 1'b0;
    bus.aAbort     = 1'b0;
    bus.aPattern   = 4'h0;
    bus.aCapCycles = 4'h0;
    bus.aIncrement = 1'b1;

    #12;
    check_vec("rst/scan_en",  32'(bus.bScanEn),    32'd0);
    check_vec("rst/scan_in",  32'(bus.bScanIn),    32'd0);
    check_vec("rst/busy",     32'(bus.bBusy),      32'd0);
    check_vec("rst/done",     32'(bus.bDone),      32'd0);
    check_vec("rst/pass",     32'(bus.bPass),      32'd0);
    check_vec("rst/captured", 32'(bus.bCaptured),  32'd0);
    check_vec("rst/inc",      32'(bus.bIncrement), 32'd1);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 4; i++) begin
      bus.aIncrement = logic'(i & 1);
      #1;
      check_vec("idle/inc_mirror", 32'(bus.bIncrement), 32'(i & 1));
      check_vec("idle/scan_en",    32'(bus.bScanEn),    32'd0);
      tick;
    end

    run_seq(4'h5, 4'd3, 4'h8, 1'b1, 12, 1'b0, "basic");
    run_seq(4'hE, 4'd5, 4'h3, 1'b1, 14, 1'b0, "wrap");
    run_seq(4'h9, 4'd0, 4'h9, 1'b1,  9, 1'b0, "c_zero");
    stuck2 = 1'b1;
    run_seq(4'h4, 4'd0, 4'h0, 1'b0,  9, 1'b0, "stuck");
    stuck2 = 1'b0;

    // Abort during LOAD cycle 2.
    bus.aPattern   = 4'hF;
    bus.aCapCycles = 4'd2;
    bus.aStart     = 1'b1;
    tick;
    bus.aStart = 1'b0;
    tick;
    tick;
    bus.aAbort     = 1'b1;
    bus.aIncrement = 1'b1;
    tick;
    bus.aAbort = 1'b0;
    check_vec("abort/scan_en", 32'(bus.bScanEn),    32'd0);
    check_vec("abort/busy",    32'(bus.bBusy),      32'd0);
    check_vec("abort/idle",    32'(bus.bIncrement), 32'd1);
    check_vec("abort/pass",    32'(bus.bPass),      32'd0);
    bus.aIncrement = 1'b0;
    count_dones(15, dones);
    check_vec("abort/no_done", 32'(dones), 32'd0);

    // Start and abort together in IDLE: start wins.
    run_seq(4'h1, 4'd1, 4'h2, 1'b1, 10, 1'b1, "post_abort");

    // Asynchronous reset while idle clears held results.
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("rst_idle/captured", 32'(bus.bCaptured), 32'd0);
    check_vec("rst_idle/pass",     32'(bus.bPass),     32'd0);
    #2;
    rst_n = 1'b1;
    tick;

    // Asynchronous reset in CAPTURE.
    bus.aPattern   = 4'h3;
    bus.aCapCycles = 4'd6;
    bus.aStart     = 1'b1;
    bus.aIncrement = 1'b0;
    tick;
    bus.aStart = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check_vec("rst_cap/inc_before",  32'(bus.bIncrement), 32'd1);
    check_vec("rst_cap/busy_before", 32'(bus.bBusy),      32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("rst_cap/busy",     32'(bus.bBusy),      32'd0);
    check_vec("rst_cap/scan_en",  32'(bus.bScanEn),    32'd0);
    check_vec("rst_cap/scan_in",  32'(bus.bScanIn),    32'd0);
    check_vec("rst_cap/done",     32'(bus.bDone),      32'd0);
    check_vec("rst_cap/pass",     32'(bus.bPass),      32'd0);
    check_vec("rst_cap/captured", 32'(bus.bCaptured),  32'd0);
    check_vec("rst_cap/inc",      32'(bus.bIncrement), 32'd0);
    #2;
    rst_n = 1'b1;
    tick;
    check_vec("rst_cap/idle_after", 32'(bus.bBusy), 32'd0);

    // aStart pulsed during UNLOAD is ignored.
    bus.aPattern   = 4'h2;
    bus.aCapCycles = 4'd2;
    bus.aStart     = 1'b1;
    tick;
    bus.aStart = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      tick;
      cyc++;
    end
    bus.aPattern = 4'hF;
    bus.aStart   = 1'b1;
    tick;
    cyc++;
    bus.aStart = 1'b0;
    while (!bus.bDone && cyc < 40) begin
      tick;
      cyc++;
    end
    check_vec("unload_start/latency",  32'(cyc),           32'd11);
    check_vec("unload_start/captured", 32'(bus.bCaptured), 32'h4);
    check_vec("unload_start/pass",     32'(bus.bPass),     32'd1);
    count_dones(15, dones);
    check_vec("unload_start/one_done", 32'(dones),     32'd0);
    check_vec("unload_start/idle",     32'(bus.bBusy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
